// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - TMDS receive channel: token-based word alignment and 10b/8b decode
module tmds_channel_decoder #(
    parameter int LOCK_COUNT   = 16,
    parameter int LOSS_TIMEOUT = 4096
) (
    input  logic       PXLCLK_I,
    input  logic       RST_I,
    input  logic [9:0] TMDS_RAW_I,
    output logic [7:0] VD_O,
    output logic [1:0] CD_O,
    output logic       VDE_O,
    output logic       LOCKED_O,
    output logic [3:0] OFFSET_O
);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int GW = $clog2(LOSS_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_COUNT);
    localparam logic [GW-1:0] GAP_MAX = GW'(LOSS_TIMEOUT);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t        state, state_n;
    logic [9:0]    raw_prev;
    logic [19:0]   win;
    logic [3:0]    offset, offset_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [GW-1:0] gap, gap_n, gap_inc;
    logic          found;
    logic [3:0]    found_k;
    logic [9:0]    word;
    logic          word_tok;
    logic [7:0]    d;
    logic [7:0]    vd_dec;

    function automatic logic is_token(input logic [9:0] w);
        return (w == 10'b1101010100) || (w == 10'b0010101011) ||
               (w == 10'b0101010100) || (w == 10'b1010101011);
    endfunction

    function automatic logic [1:0] token_cd(input logic [9:0] w);
        case (w)
            10'b0010101011: return 2'b01;
            10'b0101010100: return 2'b10;
            10'b1010101011: return 2'b11;
            default:        return 2'b00;
        endcase
    endfunction

    // Two consecutive raw words cover every possible 10-bit phase.
    assign win      = {TMDS_RAW_I, raw_prev};
    assign word     = win[offset +: 10];
    assign word_tok = is_token(word);

    // Data decode: undo optional inversion, then undo the XOR/XNOR chain.
    assign d      = word[9] ? ~word[7:0] : word[7:0];
    assign vd_dec = {d[7:1] ^ d[6:0] ^ {7{~word[8]}}, d[0]};

    // Saturating increments so neither counter can ever wrap.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    assign gap_inc = (gap == GAP_MAX) ? gap : gap + GW'(1);

    // Scan all ten phases; descending loop leaves the lowest matching offset.
    always_comb begin
        found   = 1'b0;
        found_k = 4'd0;
        for (int k = 9; k >= 0; k--) begin
            if (is_token(win[k +: 10])) begin
                found   = 1'b1;
                found_k = 4'(k);
            end
        end
    end

    // Alignment FSM next-state and counter updates.
    always_comb begin
        state_n  = state;
        offset_n = offset;
        cnt_n    = cnt;
        gap_n    = gap;
        case (state)
            SEARCH: begin
                if (found) begin
                    offset_n = found_k;
                    cnt_n    = CW'(1);
                    state_n  = VERIFY;
                end
            end
            VERIFY: begin
                if (word_tok) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc >= CNT_MAX) begin
                        state_n = LOCKED;
                        gap_n   = '0;
                    end
                end else begin
                    cnt_n   = '0;
                    state_n = SEARCH;
                end
            end
            LOCKED: begin
                if (word_tok) begin
                    gap_n = '0;
                end else if (gap_inc >= GAP_MAX) begin
                    gap_n   = '0;
                    cnt_n   = '0;
                    state_n = SEARCH;
                end else begin
                    gap_n = gap_inc;
                end
            end
            default: begin
                state_n = SEARCH;
                cnt_n   = '0;
                gap_n   = '0;
            end
        endcase
    end

    // Alignment state, offset and counter registers.
    always_ff @(posedge PXLCLK_I) begin
        if (RST_I) begin
            state    <= SEARCH;
            raw_prev <= '0;
            offset   <= '0;
            cnt      <= '0;
            gap      <= '0;
        end else begin
            state    <= state_n;
            raw_prev <= TMDS_RAW_I;
            offset   <= offset_n;
            cnt      <= cnt_n;
            gap      <= gap_n;
        end
    end

    // Output stage gated by the state being entered, so the locking token decodes at once.
    always_ff @(posedge PXLCLK_I) begin
        if (RST_I || state_n != LOCKED) begin
            VD_O  <= '0;
            CD_O  <= '0;
            VDE_O <= 1'b0;
        end else if (word_tok) begin
            VD_O  <= '0;
            CD_O  <= token_cd(word);
            VDE_O <= 1'b0;
        end else begin
            VD_O  <= vd_dec;
            VDE_O <= 1'b1;
        end
    end

    assign LOCKED_O = (state == LOCKED);
    assign OFFSET_O = offset;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - self-checking bench for tmds_channel_decoder
module tb_tmds_channel_decoder;
    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] raw;
    logic [7:0] vd;
    logic [1:0] cd;
    logic       vde;
    logic       locked;
    logic [3:0] offset;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         off_tb  = 0;
    logic [9:0] prev_w  = '0;

    localparam logic [9:0] TOK0 = 10'h354;

    always #5 clk = ~clk;

    tmds_channel_decoder #(.LOCK_COUNT(16), .LOSS_TIMEOUT(4096)) dut (
        .PXLCLK_I  (clk),
        .RST_I     (rst),
        .TMDS_RAW_I(raw),
        .VD_O      (vd),
        .CD_O      (cd),
        .VDE_O     (vde),
        .LOCKED_O  (locked),
        .OFFSET_O  (offset)
    );

    // Index of w in the token table, or -1 for a data word; the index is the control value.
    function automatic int tok_index(input logic [9:0] w);
        logic [9:0] t [4];
        t[0] = 10'h354; t[1] = 10'h0AB; t[2] = 10'h154; t[3] = 10'h2AB;
        for (int i = 0; i < 4; i++) if (w == t[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] ref_vd(input logic [9:0] w);
        logic [7:0] dd;
        logic [7:0] r;
        dd = w[9] ? ~w[7:0] : w[7:0];
        r  = dd ^ {dd[6:0], 1'b0};
        if (!w[8]) r[7:1] = ~r[7:1];
        return r;
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        do w = 10'($urandom); while (tok_index(w) >= 0);
        return w;
    endfunction

    // Serialise aligned words into raw words shifted by off_tb bits.
    task automatic send(input logic [9:0] w);
        logic [19:0] cat;
        cat    = {w, prev_w} >> (10 - off_tb);
        raw    = cat[9:0];
        prev_w = w;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            raw = 10'($urandom);
            @(posedge clk);
            #1;
            n_tests++; if (vd !== 8'h00)    begin n_fail++; $display("FAIL reset_vd: got %h want 00", vd); end
            n_tests++; if (cd !== 2'b00)    begin n_fail++; $display("FAIL reset_cd: got %b want 00", cd); end
            n_tests++; if (vde !== 1'b0)    begin n_fail++; $display("FAIL reset_vde: got %b want 0", vde); end
            n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
            n_tests++; if (offset !== 4'd0) begin n_fail++; $display("FAIL reset_offset: got %0d want 0", offset); end
        end
        rst    = 1'b0;
        prev_w = '0;
    endtask

    task automatic test_lock_offset3();
        off_tb = 3;
        for (int i = 1; i <= 17; i++) begin
            send(TOK0);
            n_tests++;
            if (locked !== (i == 17)) begin n_fail++; $display("FAIL lock3_locked step %0d: got %b want %b", i, locked, (i == 17)); end
            if (i >= 2) begin
                n_tests++;
                if (offset !== 4'd3) begin n_fail++; $display("FAIL lock3_offset step %0d: got %0d want 3", i, offset); end
            end
        end
        n_tests++; if (cd !== 2'b00) begin n_fail++; $display("FAIL lock3_cd: got %b want 00", cd); end
        n_tests++; if (vde !== 1'b0) begin n_fail++; $display("FAIL lock3_vde: got %b want 0", vde); end
        n_tests++; if (vd !== 8'h00) begin n_fail++; $display("FAIL lock3_vd: got %h want 00", vd); end
    endtask

    task automatic test_data_decode();
        logic [9:0] last;
        logic [9:0] w;
        logic [1:0] exp_cd;
        int         ti;
        send(10'h100);
        send(10'h200);
        n_tests++; if (vd !== 8'h00) begin n_fail++; $display("FAIL dec100_vd: got %h want 00", vd); end
        n_tests++; if (vde !== 1'b1) begin n_fail++; $display("FAIL dec100_vde: got %b want 1", vde); end
        n_tests++; if (cd !== 2'b00) begin n_fail++; $display("FAIL dec100_cd: got %b want 00", cd); end
        send(TOK0);
        n_tests++; if (vd !== 8'hFF) begin n_fail++; $display("FAIL dec200_vd: got %h want ff", vd); end
        n_tests++; if (vde !== 1'b1) begin n_fail++; $display("FAIL dec200_vde: got %b want 1", vde); end
        n_tests++; if (cd !== 2'b00) begin n_fail++; $display("FAIL dec200_cd: got %b want 00", cd); end
        last   = TOK0;
        exp_cd = 2'b00;
        for (int i = 0; i < 300; i++) begin
            w = 10'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: w = 10'h354;
                    1: w = 10'h0AB;
                    2: w = 10'h154;
                    default: w = 10'h2AB;
                endcase
            end
            send(w);
            ti = tok_index(last);
            if (ti >= 0) begin
                exp_cd = 2'(ti);
                n_tests++; if (vde !== 1'b0 || vd !== 8'h00 || cd !== exp_cd) begin n_fail++; $display("FAIL rand_tok %0d word %h: got vde=%b vd=%h cd=%b want 0 00 %b", i, last, vde, vd, cd, exp_cd); end
            end else begin
                n_tests++; if (vde !== 1'b1 || vd !== ref_vd(last) || cd !== exp_cd) begin n_fail++; $display("FAIL rand_data %0d word %h: got vde=%b vd=%h cd=%b want 1 %h %b", i, last, vde, vd, cd, ref_vd(last), exp_cd); end
            end
            n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL rand_locked %0d: got %b want 1", i, locked); end
            last = w;
        end
    endtask

    task automatic test_verify_fail();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        prev_w = '0;
        off_tb = $urandom_range(0, 9);
        for (int i = 0; i < 23; i++) begin
            send((i == 5) ? 10'h100 : TOK0);
            n_tests++;
            if (locked !== (i == 22)) begin n_fail++; $display("FAIL vfail_locked step %0d: got %b want %b", i, locked, (i == 22)); end
        end
        n_tests++; if (offset !== 4'(off_tb)) begin n_fail++; $display("FAIL vfail_offset: got %0d want %0d", offset, off_tb); end
    endtask

    task automatic test_loss_of_lock();
        logic [9:0] words[$];
        logic [9:0] last;
        logic [1:0] exp_cd;
        logic       exp_lock;
        int         ti;
        for (int i = 0; i < 4095; i++) words.push_back(rand_data());
        words.push_back(TOK0);
        for (int i = 0; i < 4097; i++) words.push_back(rand_data());
        last   = TOK0;
        exp_cd = 2'b00;
        for (int i = 0; i < words.size(); i++) begin
            send(words[i]);
            exp_lock = (i != words.size() - 1);
            n_tests++; if (locked !== exp_lock) begin n_fail++; $display("FAIL loss_locked step %0d: got %b want %b", i, locked, exp_lock); end
            ti = tok_index(last);
            if (!exp_lock) begin
                n_tests++; if (vde !== 1'b0 || vd !== 8'h00 || cd !== 2'b00) begin n_fail++; $display("FAIL loss_gated: got vde=%b vd=%h cd=%b want 0 00 00", vde, vd, cd); end
            end else if (ti >= 0) begin
                exp_cd = 2'(ti);
                n_tests++; if (vde !== 1'b0 || cd !== exp_cd) begin n_fail++; $display("FAIL loss_tok step %0d: got vde=%b cd=%b want 0 %b", i, vde, cd, exp_cd); end
            end else begin
                n_tests++; if (vde !== 1'b1 || vd !== ref_vd(last)) begin n_fail++; $display("FAIL loss_data step %0d: got vde=%b vd=%h want 1 %h", i, vde, vd, ref_vd(last)); end
            end
            last = words[i];
        end
    endtask

    task automatic test_reset_mid_lock();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        prev_w = '0;
        off_tb = $urandom_range(1, 9);
        for (int i = 0; i < 17; i++) send(TOK0);
        for (int i = 0; i < 4; i++) send(rand_data());
        n_tests++; if (locked !== 1'b1 || vde !== 1'b1) begin n_fail++; $display("FAIL midrst_prelock: got locked=%b vde=%b want 1 1", locked, vde); end
        rst = 1'b1;
        raw = 10'($urandom);
        @(posedge clk);
        #1;
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL midrst_locked: got %b want 0", locked); end
        n_tests++; if (offset !== 4'd0) begin n_fail++; $display("FAIL midrst_offset: got %0d want 0", offset); end
        n_tests++; if (vd !== 8'h00 || cd !== 2'b00 || vde !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: got vd=%h cd=%b vde=%b want 00 00 0", vd, cd, vde); end
        rst    = 1'b0;
        prev_w = '0;
        for (int i = 1; i <= 17; i++) begin
            send(TOK0);
            n_tests++;
            if (locked !== (i == 17)) begin n_fail++; $display("FAIL midrst_relock step %0d: got %b want %b", i, locked, (i == 17)); end
        end
        n_tests++; if (offset !== 4'(off_tb)) begin n_fail++; $display("FAIL midrst_offset_relock: got %0d want %0d", offset, off_tb); end
    endtask

    initial begin
        rst = 1'b1;
        raw = '0;
        test_reset();
        test_lock_offset3();
        test_data_decode();
        test_verify_fail();
        test_loss_of_lock();
        test_reset_mid_lock();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tmds_channel_decoder.md
Name: tmds_channel_decoder

Overview:
- Receive-side counterpart of the TMDS transmit path. Handles one TMDS channel; the HDMI receive top instantiates three.
- Input is 10-bit raw words from an external 1:10 deserializer, with unknown bit phase. The block finds word alignment using control tokens and decodes 10b to 8b pixel data or 2-bit control.
- Outputs mirror the transmitter's encoder inputs: VD, CD, VDE. HS/VS are taken from CD of the blue channel at top level.

Parameters:
- LOCK_COUNT, 16: consecutive control tokens at one offset required to declare lock.
- LOSS_TIMEOUT, 4096: cycles without a control token at the locked offset before lock is dropped.

Ports:
- PXLCLK_I  in  1  pixel clock; the only clock.
- RST_I  in  1  synchronous, active-high reset.
- TMDS_RAW_I  in  10  deserialized word; first-received bit in bit 0, matching LSB-first transmission.
- VD_O  out  8  decoded pixel byte.
- CD_O  out  2  decoded control value, {VS,HS} on the blue channel.
- VDE_O  out  1  video data enable.
- LOCKED_O  out  1  word alignment locked.
- OFFSET_O  out  4  current alignment offset, 0..9.

Behaviour:
- Window: raw_prev registers TMDS_RAW_I each cycle. win[19:0] = {TMDS_RAW_I, raw_prev}. Candidate word at offset k is win[k+9:k], k = 0..9.
- Control tokens, written q[9:0]:
  - 1101010100 -> CD=00
  - 0010101011 -> CD=01
  - 0101010100 -> CD=10
  - 1010101011 -> CD=11
- States: SEARCH, VERIFY, LOCKED. Reset enters SEARCH with offset=0, cnt=0.
- SEARCH:
  - Test all 10 candidate words each cycle.
  - If any is a token, latch the lowest matching k as offset, set cnt=1, go to VERIFY.
  - Otherwise stay in SEARCH.
- VERIFY:
  - Word at latched offset is a token: cnt++. When cnt reaches LOCK_COUNT, go to LOCKED and clear the gap counter.
  - Word is a non-token: go to SEARCH, cnt=0. A new search starts on the next cycle.
- LOCKED:
  - Token at offset: clear gap counter.
  - Otherwise: gap counter++. When the counter reaches LOSS_TIMEOUT, go to SEARCH.
  - Offset is frozen while in LOCKED.
- Decode path (one register stage; outputs update on the PXLCLK_I edge after the window word is present), word w at current offset:
  - Token: VDE_O=0, CD_O=token value, VD_O=0.
  - Non-token: VDE_O=1, CD_O holds its last value.
    - d = w[9] ? ~w[7:0] : w[7:0].
    - VD_O[0] = d[0].
    - For i = 1..7: VD_O[i] = w[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- Outputs are gated by lock. When not in LOCKED: VDE_O=0, VD_O=0, CD_O=0.
- LOCKED_O=1 exactly while in LOCKED. OFFSET_O reflects the latched offset in every state.
- Reset values, forced on the edge where RST_I=1 from any state including mid-lock:
  - VD_O=0, CD_O=0, VDE_O=0, LOCKED_O=0, OFFSET_O=0, raw_prev=0, counters=0.
- Boundaries:
  - The token that completes LOCK_COUNT is decoded as a token on the first LOCKED output cycle.
  - A gap count equal to LOSS_TIMEOUT-1 followed by a token keeps lock.
  - Counters saturate and never wrap.

Test Plan:
- Reset: assert RST_I for 3 cycles with random TMDS_RAW_I -> all outputs 0, LOCKED_O=0.
- Lock at offset 3: feed a continuous 1101010100 token stream delayed by 3 bits -> OFFSET_O=3. LOCKED_O rises after 16 consecutive tokens, then CD_O=00 and VDE_O=0.
- Data decode after lock: send aligned word 0x100 -> VD_O=0x00, VDE_O=1. Send 0x200 -> VD_O=0xFF, VDE_O=1. CD_O holds its prior token value throughout.
- Verify failure: aligned tokens x5 then word 0x100 -> back to SEARCH, LOCKED_O stays 0. Then 16 tokens -> lock.
- Loss of lock: after lock, send 4095 data words then a token -> still locked. Send 4096 data words -> LOCKED_O falls, and VD_O=0, VDE_O=0.
- Reset mid-lock: assert RST_I during the LOCKED data phase -> next cycle all outputs 0, OFFSET_O=0. Re-lock requires 16 fresh tokens.
